// File: rtl/lsu_axi.sv
// lsu_axi: load/store unit with an AXI4-Lite-style master port.
//
// Takes one memory request at a time from the execute stage. It aligns store
// data and strobes to the bus lanes and sign- or zero-extends load data. It
// also reports bus errors and illegal accesses on a one-cycle response pulse.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned requests skip the bus and respond with
//               resp_err = 1 and resp_misalign = 1 one cycle after acceptance.
//   undefined : misaligned requests have their low log2(bytes) address bits
//               cleared and complete normally; resp_misalign is tied to 0.
//
// Handshake rule, identical on every channel (req, ar, r, aw, w, b): a
// transfer happens on a rising clk edge where valid && ready are both 1. A
// source holds valid, and everything qualified by it, stable until that edge.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_*                    request from EXU (req_ready high only in IDLE)
//   resp_*                   one-cycle completion pulse with data/err/misalign
//   ar*/r*                   AXI read address / read data channels
//   aw*/w*/b*                AXI write address / write data / write resp
//   dbg_state                current FSM state, for checkers and debug
module lsu_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_misalign,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [2:0]          dbg_state
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIDX_W   = $clog2(DATA_W);
  localparam bit NO_DWORD = (DATA_W == 32);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [3:0]          w_req_lowmask;
  logic                w_req_illegal;
  logic                w_trap;
  logic                w_aw_all;
  logic                w_w_all;
  logic [OFF_W-1:0]    w_lane;
  logic [OFF_W+2:0]    w_shamt;
  logic [DATA_W-1:0]   w_rshift;
  logic [7:0]          w_nbits;
  logic [DATA_W-1:0]   w_keep;
  logic                w_sign;
  logic [DATA_W-1:0]   w_load_ext;
  logic [STRB_W-1:0]   w_strb_base;

  // Low address bits that must be zero for a naturally aligned access.
  assign w_req_lowmask = (4'd1 << req_size) - 4'd1;
  // A dword access cannot be carried by a 32-bit bus.
  assign w_req_illegal = NO_DWORD && (req_size == 2'd3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_req_mis;
  logic r_misalign;

  assign w_req_mis = |(req_addr[2:0] & w_req_lowmask[2:0]);
  assign w_trap    = w_req_mis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (r_state == IDLE && req_valid) begin
      r_misalign <= w_trap;
    end else if (r_state == RESP) begin
      r_misalign <= 1'b0;
    end
  end

  assign resp_misalign = r_misalign;
`else
  assign w_trap        = 1'b0;
  assign resp_misalign = 1'b0;
`endif

  // Each write channel counts as finished once it has handshaken, in an
  // earlier cycle or in this one.
  assign w_aw_all = r_aw_done | (awvalid & awready);
  assign w_w_all  = r_w_done  | (wvalid & wready);

  // Lane arithmetic on the latched (already size-aligned) address.
  assign w_lane  = r_addr[OFF_W-1:0];
  assign w_shamt = {w_lane, 3'b000};

  // Load extension: keep the low 8 << size bits of the lane-shifted word and
  // fill the rest with the sign bit (or zeros). Shifting by DATA_W yields an
  // all-zero value, so the full-width case keeps every bit.
  always_comb begin
    w_rshift   = rdata >> w_shamt;
    w_nbits    = 8'd8 << r_size;
    w_keep     = ~({DATA_W{1'b1}} << w_nbits);
    w_sign     = ~r_unsigned & w_rshift[SIDX_W'(w_nbits - 8'd1)];
    w_load_ext = (w_rshift & w_keep) | (w_sign ? ~w_keep : '0);
  end

  always_comb begin
    w_strb_base = '0;
    case (r_size)
      2'd0:    w_strb_base = STRB_W'(1);
      2'd1:    w_strb_base = STRB_W'(3);
      2'd2:    w_strb_base = STRB_W'(15);
      default: w_strb_base = '1;
    endcase
  end

  // Bus payloads come straight from latched registers, so they are stable
  // for as long as the matching valid is held.
  assign araddr = r_addr & ~(ADDR_W'(STRB_W - 1));
  assign awaddr = r_addr & ~(ADDR_W'(STRB_W - 1));
  assign wdata  = r_wdata << w_shamt;
  assign wstrb  = w_strb_base << w_lane;

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_illegal || w_trap) begin
            w_next = RESP;
          end else if (req_wen) begin
            w_next = WR_AW;
          end else begin
            w_next = RD_A;
          end
        end
      end
      RD_A: begin
        arvalid = 1'b1;
        if (arready) w_next = RD_D;
      end
      RD_D: begin
        rready = 1'b1;
        if (rvalid) w_next = RESP;
      end
      WR_AW: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if (w_aw_all && w_w_all) w_next = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            // Clearing the low size bits aligns a misaligned request when
            // the trap is off; aligned requests pass through unchanged.
            r_addr     <= req_addr & ~ADDR_W'(w_req_lowmask);
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= w_req_illegal | w_trap;
          end
        end
        RD_D: begin
          if (rvalid) begin
            r_rdata <= w_load_ext;
            r_err   <= (rresp != 2'b00);
          end
        end
        WR_AW: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
        end
        WR_B: begin
          if (bvalid) r_err <= (bresp != 2'b00);
        end
        RESP: begin
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi.sv
module tb_lsu_axi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32-bit data bus instance
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err, resp_misalign;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic [2:0]  dbg_state;

  // 64-bit data bus instance
  logic        d_req_valid, d_req_ready, d_req_wen, d_req_unsigned;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic [1:0]  d_req_size;
  logic        d_resp_valid, d_resp_err, d_resp_misalign;
  logic [63:0] d_resp_rdata;
  logic [31:0] d_araddr, d_awaddr;
  logic [63:0] d_rdata, d_wdata;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;
  logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [1:0]  d_rresp, d_bresp;
  logic [7:0]  d_wstrb;
  logic [2:0]  d_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_axi #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misalign(resp_misalign),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  lsu_axi #(.ADDR_W(32), .DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen),
    .req_addr(d_req_addr), .req_wdata(d_req_wdata), .req_size(d_req_size),
    .req_unsigned(d_req_unsigned),
    .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
    .resp_misalign(d_resp_misalign),
    .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready),
    .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready),
    .awaddr(d_awaddr), .awvalid(d_awvalid), .awready(d_awready),
    .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
    .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready),
    .dbg_state(d_dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Zero-wait load on the 32-bit instance; checks the N+1 / N+3 timing.
  task automatic load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] bus_data, input logic [1:0] bus_resp,
                        input logic [31:0] exp_araddr, input logic [31:0] exp_data,
                        input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_size = size; req_unsigned = uns;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~addr;
    chk({tag, "_arvalid"}, arvalid, 1'b1);
    chk({tag, "_araddr"}, araddr, exp_araddr);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk({tag, "_rready"}, rready, 1'b1);
    rvalid = 1'b1; rdata = bus_data; rresp = bus_resp;
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_rdata"}, resp_rdata, exp_data);
    chk({tag, "_err"}, resp_err, exp_err);
    chk({tag, "_misalign"}, resp_misalign, 1'b0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, resp_valid, 1'b0);
    chk({tag, "_idle"}, req_ready, 1'b1);
  endtask

  // Zero-wait store on the 32-bit instance, aw and w accepted together.
  task automatic store32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] data, input logic [31:0] exp_awaddr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_size = size; req_wdata = data;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_awvalid"}, awvalid, 1'b1);
    chk({tag, "_wvalid"}, wvalid, 1'b1);
    chk({tag, "_awaddr"}, awaddr, exp_awaddr);
    chk({tag, "_wdata"}, wdata, exp_wdata);
    chk({tag, "_wstrb"}, wstrb, exp_wstrb);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk({tag, "_aw_drop"}, awvalid, 1'b0);
    chk({tag, "_bready"}, bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_err"}, resp_err, 1'b0);
    chk({tag, "_rdata0"}, resp_rdata, 32'h0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, resp_valid, 1'b0);
  endtask

  task automatic load64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] bus_data,
                        input logic [31:0] exp_araddr, input logic [63:0] exp_data);
    @(negedge clk);
    d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = addr; d_req_size = size;
    d_req_unsigned = uns;
    @(negedge clk);
    d_req_valid = 1'b0;
    chk({tag, "_arvalid"}, d_arvalid, 1'b1);
    chk({tag, "_araddr"}, d_araddr, exp_araddr);
    d_arready = 1'b1;
    @(negedge clk);
    d_arready = 1'b0;
    d_rvalid = 1'b1; d_rdata = bus_data; d_rresp = 2'b00;
    @(negedge clk);
    d_rvalid = 1'b0;
    chk({tag, "_resp_valid"}, d_resp_valid, 1'b1);
    chk({tag, "_rdata"}, d_resp_rdata, exp_data);
    chk({tag, "_err"}, d_resp_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'd0;
    req_unsigned = 1'b0; arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    d_req_valid = 1'b0; d_req_wen = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    d_req_size = 2'd0; d_req_unsigned = 1'b0; d_arready = 1'b0; d_rdata = '0;
    d_rresp = 2'b00; d_rvalid = 1'b0; d_awready = 1'b0; d_wready = 1'b0;
    d_bresp = 2'b00; d_bvalid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", dbg_state, 3'd0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_misalign", resp_misalign, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst64_state", d_dbg_state, 3'd0);
    rst = 1'b1;

    // Loads on the 32-bit bus
    load32("ld_sb3", 32'h8000_0003, 2'd0, 1'b0, 32'h8012_3456, 2'b00,
           32'h8000_0000, 32'hFFFF_FF80, 1'b0);
    load32("ld_ub2", 32'h0000_0042, 2'd0, 1'b1, 32'h11F0_2233, 2'b00,
           32'h0000_0040, 32'h0000_00F0, 1'b0);
    load32("ld_sh0", 32'h0000_0200, 2'd1, 1'b0, 32'hFFFF_7FFF, 2'b00,
           32'h0000_0200, 32'h0000_7FFF, 1'b0);
    load32("ld_err", 32'h0000_0102, 2'd1, 1'b0, 32'h8001_0000, 2'b10,
           32'h0000_0100, 32'hFFFF_8001, 1'b1);

    // Store with both channels ready at once
    store32("st_b1", 32'h0000_0021, 2'd0, 32'h0000_00A5,
            32'h0000_0020, 32'h0000_A500, 4'b0010);

    // Store: aw held off 3 cycles, b delayed 5 cycles
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0002; req_size = 2'd1;
    req_wdata = 32'h0000_BEEF; awready = 1'b0; wready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'h1234_5678;
    chk("st_awvalid", awvalid, 1'b1);
    chk("st_wvalid", wvalid, 1'b1);
    chk("st_awaddr", awaddr, 32'h8000_0000);
    chk("st_wdata", wdata, 32'hBEEF_0000);
    chk("st_wstrb", wstrb, 4'b1100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wready = 1'b0;
      chk("st_aw_hold", awvalid, 1'b1);
      chk("st_w_dropped", wvalid, 1'b0);
      chk("st_aw_addr_hold", awaddr, 32'h8000_0000);
      chk("st_no_bready", bready, 1'b0);
    end
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("st_aw_dropped", awvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("st_bready", bready, 1'b1);
      chk("st_b_no_resp", resp_valid, 1'b0);
      chk("st_b_busy", req_ready, 1'b0);
      @(negedge clk);
    end
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    chk("st_resp_valid", resp_valid, 1'b1);
    chk("st_resp_err", resp_err, 1'b0);
    chk("st_resp_busy", req_ready, 1'b0);
    @(negedge clk);
    chk("st_pulse_end", resp_valid, 1'b0);
    chk("st_idle", req_ready, 1'b1);

    // Illegal dword access on the 32-bit bus
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0010; req_size = 2'd3;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ill_arvalid", arvalid, 1'b0);
    chk("ill_resp_valid", resp_valid, 1'b1);
    chk("ill_err", resp_err, 1'b1);
    chk("ill_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    chk("ill_pulse_end", resp_valid, 1'b0);
    chk("ill_err_clear", resp_err, 1'b0);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0101; req_size = 2'd2;
    req_unsigned = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis_arvalid", arvalid, 1'b0);
    chk("mis_resp_valid", resp_valid, 1'b1);
    chk("mis_err", resp_err, 1'b1);
    chk("mis_flag", resp_misalign, 1'b1);
    @(negedge clk);
    chk("mis_pulse_end", resp_valid, 1'b0);
    chk("mis_flag_clear", resp_misalign, 1'b0);
`else
    load32("mis_ld", 32'h8000_0101, 2'd2, 1'b1, 32'hCAFE_BABE, 2'b00,
           32'h8000_0100, 32'hCAFE_BABE, 1'b0);
`endif

    // Reset while waiting for read data
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0300; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rr_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rr_rready", rready, 1'b1);
    chk("rr_state", dbg_state, 3'd2);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst = 1'b1; rvalid = 1'b0;
    chk("rr_arvalid0", arvalid, 1'b0);
    chk("rr_rready0", rready, 1'b0);
    chk("rr_no_resp", resp_valid, 1'b0);
    chk("rr_req_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("rr_no_resp2", resp_valid, 1'b0);

    // 64-bit bus
    load64("d_ld_uw4", 32'h0000_1004, 2'd2, 1'b1, 64'h1234_5678_0000_0000,
           32'h0000_1000, 64'h0000_0000_1234_5678);
    load64("d_ld_sw4", 32'h0000_1004, 2'd2, 1'b0, 64'h8765_4321_0000_0000,
           32'h0000_1000, 64'hFFFF_FFFF_8765_4321);
    load64("d_ld_dw", 32'h0000_2000, 2'd3, 1'b0, 64'h8000_0000_0000_0001,
           32'h0000_2000, 64'h8000_0000_0000_0001);

    @(negedge clk);
    d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 32'h0000_3006; d_req_size = 2'd1;
    d_req_wdata = 64'h0000_0000_0000_BEEF; d_awready = 1'b1; d_wready = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b0;
    chk("d_st_awaddr", d_awaddr, 32'h0000_3000);
    chk("d_st_wdata", d_wdata, 64'hBEEF_0000_0000_0000);
    chk("d_st_wstrb", d_wstrb, 8'hC0);
    @(negedge clk);
    d_awready = 1'b0; d_wready = 1'b0;
    chk("d_st_bready", d_bready, 1'b1);
    d_bvalid = 1'b1; d_bresp = 2'b11;
    @(negedge clk);
    d_bvalid = 1'b0;
    chk("d_st_resp_valid", d_resp_valid, 1'b1);
    chk("d_st_berr", d_resp_err, 1'b1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi.md
Name: lsu_axi

Overview:
- Parametrised load/store unit that replaces the fixed 32-bit LSU with its embedded SRAM.
- Accepts one memory request at a time from the execute stage and drives an external AXI4-Lite-style master port.
- Handles byte-lane alignment, store strobes, load sign/zero extension and bus error reporting.
- Sits between EXU/WBU and the memory crossbar.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus data width. Legal values are 32 or 64.
- OFF_W, $clog2(DATA_W/8), byte-offset bits. Derived; must not be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  LSU idle, able to accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  bus error or illegal access.
- resp_misalign  out  1  misaligned-access fault (see Optional Feature).
- araddr  out  ADDR_W  read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  DATA_W  read data.
- rresp  in  2  read response.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- awaddr  out  ADDR_W  write address.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  DATA_W  write data.
- wstrb  out  DATA_W/8  write byte strobes.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bresp  in  2  write response.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state goes to IDLE.
  - arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err and resp_misalign all go to 0.
  - resp_rdata goes to 0.
  - An in-flight transaction is abandoned and produces no response.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On req_valid && req_ready, latch addr, wdata, size, unsigned and wen.
  - Load goes to RD_A; store goes to WR_AW.
- RD_A: arvalid = 1. On arready, go to RD_D.
- RD_D: rready = 1. On rvalid, capture the extended data and set err = (rresp != 0), then go to RESP.
- WR_AW:
  - awvalid and wvalid are both asserted on entry.
  - Each one drops independently after its own handshake.
  - When both handshakes are complete (including in the same cycle), go to WR_B.
- WR_B: bready = 1. On bvalid, set err = (bresp != 0), then go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then return to IDLE.
- Minimum load latency: request accepted at cycle N, arvalid high at N+1, rvalid at N+2, resp_valid at N+3.
- Minimum store latency: the same, N+3.
- Addressing and data alignment:
  - araddr and awaddr = latched addr with the low OFF_W bits cleared.
  - lane = addr[OFF_W-1:0].
  - Store: wdata = req_wdata << (lane*8); wstrb = ((1 << (1 << size)) - 1) << lane.
  - Load: shifted = rdata >> (lane*8). Take the low 8, 16, 32 or 64 bits per size, then sign- or zero-extend to DATA_W.
- Illegal size: size == 3 with DATA_W == 32 skips the bus, goes directly to RESP, and sets resp_err = 1.
- Bus outputs are held stable while their valid is high and not yet accepted.
- Changes on req_* while not in IDLE are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- A request is misaligned when addr mod (1 << size) != 0.
- Defined:
  - A misaligned request performs no bus access.
  - The FSM goes IDLE -> RESP, so resp_valid is high one cycle after acceptance.
  - resp_err = 1 and resp_misalign = 1.
- Undefined:
  - resp_misalign is tied to 0.
  - A misaligned request is issued with the low log2(bytes) bits of addr cleared before lane computation.
  - It completes normally.

Test Plan:
- DATA_W = 32, load: addr 0x8000_0003, size 0, signed, bus returns 0x80xx_xxxx with 0x80 in byte 3 -> resp_rdata = 0xFFFF_FF80, araddr = 0x8000_0000, resp_valid at N+3.
- DATA_W = 32, store: addr 0x8000_0002, size 1, wdata 0x0000_BEEF -> wstrb = 4'b1100, wdata = 0xBEEF_0000. Hold awready low 3 cycles with wready high: wvalid drops after 1 cycle, awvalid stays high until accepted.
- Load with rresp = 2'b10 -> resp_err = 1, resp_rdata still the extended data.
- Store with bvalid delayed 5 cycles -> bready high through WR_B, single resp_valid pulse, req_ready low until after RESP.
- DATA_W = 64, load: addr 0x...04, size 2, unsigned, rdata = 0x1234_5678_0000_0000 -> resp_rdata = 0x0000_0000_1234_5678. Size 3 load with DATA_W = 32 -> resp_err = 1, no arvalid.
- Misaligned word load at 0x...01:
  - With LSU_MISALIGN_TRAP_EN: no arvalid, resp_valid at N+1, resp_misalign = 1.
  - Without it: araddr = 0x...00, normal completion.
- Assert rst low while in RD_D -> arvalid and rready go to 0 at the next edge, no resp_valid, req_ready = 1.
